uart_mitm_channel: RTL

Parametrised single-direction man-in-the-middle channel. It receives UART frames on rx_in, applies the currently selected MITM transform, buffers the results in a small FIFO and retransmits them on tx_out. Two instances, one per direction, sit between the interface pins and the mode controller in the top level. This block generalises the fixed 8N1, 4-mode datapath to configurable data width, parity, FIFO depth and an extended mode set, and adds error and overflow reporting.

---
 rtl/uart_mitm_channel.sv | 316 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mitm_channel.sv
// Single-direction UART man-in-the-middle channel: receive a frame, apply the
// selected transform, queue the result in a small FIFO, retransmit it.
module uart_mitm_channel #(
    parameter int CLK_FREQ_HZ   = 12_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int NUM_DATA_BITS = 8,
    parameter int PARITY        = 0,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     rx_in,
    output logic                     tx_out,
    input  logic [2:0]               mode,
    input  logic [NUM_DATA_BITS-1:0] sub_data,
    input  logic                     tx_hold,
    output logic                     comm_active,
    output logic                     frame_err,
    output logic                     overflow
);
    localparam int BIT_TICKS = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW        = $clog2(BIT_TICKS + 1);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int NB        = NUM_DATA_BITS;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [2:0] M_SUB   = 3'd1;
    localparam logic [2:0] M_BLOCK = 3'd2;
    localparam logic [2:0] M_ROT13 = 3'd3;
    localparam logic [2:0] M_XOR   = 3'd4;

    // Handshake: the RX side raises push_q for exactly one cycle with the
    // transformed word in push_data_q; the FIFO takes it that cycle unless
    // full (in which case the word is dropped and overflow pulses). The TX
    // side pops the head in the same cycle it leaves IDLE.

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [2:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [NB-1:0] rx_shift_q, rx_shift_d;
    logic          rx_par_q, rx_par_d;
    logic [2:0]    mode_q, mode_d;
    logic [NB-1:0] sub_q, sub_d;
    logic          push_q, push_d;
    logic [NB-1:0] push_data_q, push_data_d;
    logic          ferr_q, ferr_d;
    logic          rx_tick, rx_par_bad;
    logic [8:0]    rx_wide;
    logic [NB-1:0] rot_data, xform_data;

    logic [NB-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   fifo_cnt_q, fifo_cnt_d;
    logic          fifo_full, fifo_wr, ovf_d, ovf_q;
    logic [NB-1:0] fifo_head;

    logic [2:0]    tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [NB-1:0] tx_shift_q, tx_shift_d;
    logic          tx_par_q, tx_par_d;
    logic          tx_q, tx_d, tx_pop, tx_tick;
    logic          comm_q, comm_d;

    assign rx_tick    = (rx_cnt_q == '0);
    assign tx_tick    = (tx_cnt_q == '0);
    // rx_par_q accumulates data and parity bits; odd total is correct for odd parity
    assign rx_par_bad = (PARITY == 1) ? ~rx_par_q : ((PARITY == 2) ? rx_par_q : 1'b0);
    assign fifo_full  = (fifo_cnt_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_head  = mem_q[rd_ptr_q];
    assign fifo_wr    = push_q && (!fifo_full || tx_pop);
    assign ovf_d      = push_q && fifo_full && !tx_pop;

    // ROT13 within the two ASCII letter ranges; wider widths only
    always_comb begin
        rx_wide  = 9'(rx_shift_q);
        rot_data = rx_shift_q;
        if (NUM_DATA_BITS >= 7) begin
            if ((rx_wide >= 9'h041 && rx_wide <= 9'h04D) || (rx_wide >= 9'h061 && rx_wide <= 9'h06D))
                rot_data = NB'(rx_wide + 9'd13);
            else if ((rx_wide >= 9'h04E && rx_wide <= 9'h05A) || (rx_wide >= 9'h06E && rx_wide <= 9'h07A))
                rot_data = NB'(rx_wide - 9'd13);
        end
    end

    // Transform selected by the mode latched at the start of the frame
    always_comb begin
        case (mode_q)
            M_SUB:   xform_data = sub_q;
            M_ROT13: xform_data = rot_data;
            M_XOR:   xform_data = rx_shift_q ^ sub_q;
            default: xform_data = rx_shift_q;
        endcase
    end

    // RX FSM next state: mid-bit sampling driven by a down-counter
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_d    = rx_par_q;
        mode_d      = mode_q;
        sub_d       = sub_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        ferr_d      = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = CW'(BIT_TICKS / 2);
                end
            end
            S_START: begin
                if (!rx_tick) rx_cnt_d = rx_cnt_q - CW'(1);
                else if (rx_s2_q) rx_state_d = S_IDLE;
                else begin
                    rx_state_d = S_DATA;
                    rx_cnt_d   = CW'(BIT_TICKS - 1);
                    rx_bit_d   = '0;
                    rx_par_d   = 1'b0;
                    mode_d     = mode;
                    sub_d      = sub_data;
                end
            end
            S_DATA: begin
                if (!rx_tick) rx_cnt_d = rx_cnt_q - CW'(1);
                else begin
                    rx_cnt_d   = CW'(BIT_TICKS - 1);
                    rx_shift_d = {rx_s2_q, rx_shift_q[NB-1:1]};
                    rx_par_d   = rx_par_q ^ rx_s2_q;
                    if (rx_bit_q == 4'(NB - 1))
                        rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    else
                        rx_bit_d = rx_bit_q + 4'd1;
                end
            end
            S_PARITY: begin
                if (!rx_tick) rx_cnt_d = rx_cnt_q - CW'(1);
                else begin
                    rx_cnt_d   = CW'(BIT_TICKS - 1);
                    rx_par_d   = rx_par_q ^ rx_s2_q;
                    rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (!rx_tick) rx_cnt_d = rx_cnt_q - CW'(1);
                else begin
                    rx_state_d = S_IDLE;
                    if (!rx_s2_q || rx_par_bad) ferr_d = 1'b1;
                    else if (mode_q != M_BLOCK) begin
                        push_d      = 1'b1;
                        push_data_d = xform_data;
                    end
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // TX FSM next state: each bit held for BIT_TICKS cycles, LSB first
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (fifo_cnt_q != '0 && !tx_hold) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_head;
                    tx_par_d   = (PARITY == 1) ? ~(^fifo_head) : ^fifo_head;
                    tx_cnt_d   = CW'(BIT_TICKS - 1);
                    tx_d       = 1'b0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (!tx_tick) tx_cnt_d = tx_cnt_q - CW'(1);
                else begin
                    tx_cnt_d   = CW'(BIT_TICKS - 1);
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (!tx_tick) tx_cnt_d = tx_cnt_q - CW'(1);
                else begin
                    tx_cnt_d = CW'(BIT_TICKS - 1);
                    if (tx_bit_q == 4'(NB - 1)) begin
                        if (PARITY != 0) begin
                            tx_state_d = S_PARITY;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = S_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (!tx_tick) tx_cnt_d = tx_cnt_q - CW'(1);
                else begin
                    tx_cnt_d   = CW'(BIT_TICKS - 1);
                    tx_state_d = S_STOP;
                    tx_d       = 1'b1;
                end
            end
            S_STOP: begin
                if (!tx_tick) tx_cnt_d = tx_cnt_q - CW'(1);
                else begin
                    tx_state_d = S_IDLE;
                    tx_d       = 1'b1;
                end
            end
            default: begin
                tx_state_d = S_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    // FIFO occupancy next state
    always_comb begin
        case ({fifo_wr, tx_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + (AW+1)'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - (AW+1)'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Busy: any frame in flight, queued, or about to be queued
    assign comm_d = (rx_state_q != S_IDLE) || (tx_state_q != S_IDLE) || (fifo_cnt_q != '0) || push_q;

    // FIFO storage, no reset needed: occupancy guards every read
    always_ff @(posedge sys_clk) begin
        if (fifo_wr) mem_q[wr_ptr_q] <= push_data_q;
    end

    // All control state with synchronous reset
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_par_q    <= 1'b0;
            mode_q      <= '0;
            sub_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            ferr_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_par_q    <= 1'b0;
            tx_q        <= 1'b1;
            comm_q      <= 1'b0;
        end else begin
            rx_s1_q     <= rx_in;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_par_q    <= rx_par_d;
            mode_q      <= mode_d;
            sub_q       <= sub_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            ferr_q      <= ferr_d;
            if (fifo_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (tx_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            fifo_cnt_q  <= fifo_cnt_d;
            ovf_q       <= ovf_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_q    <= tx_par_d;
            tx_q        <= tx_d;
            comm_q      <= comm_d;
        end
    end

    assign tx_out      = tx_q;
    assign comm_active = comm_q;
    assign frame_err   = ferr_q;
    assign overflow    = ovf_q;

endmodule
